// File: rtl/axi_lite_pkg.sv
// Shared AXI4-Lite types and constants for the slave register bank.
package axi_lite_pkg;

  localparam int AXI_DATA_W = 32;
  localparam int AXI_STRB_W = AXI_DATA_W / 8;

  typedef logic [1:0] axi_resp_t;

  localparam axi_resp_t RESP_OKAY   = 2'b00;
  localparam axi_resp_t RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    W_IDLE,
    W_COMMIT,
    W_RESP
  } wr_state_t;

endpackage

// File: rtl/axi_lite_regfile.sv
// Byte-strobed register array with a combinational read port and fabric outputs.
// With AXI_LITE_SLAVE_ID_REG_EN the last register is a constant ID_VALUE.
module axi_lite_regfile
  import axi_lite_pkg::*;
#(
  parameter int                    NUM_REGS = 16,
  parameter logic [AXI_DATA_W-1:0] ID_VALUE = 32'hA11E_0001,
  parameter int                    IDX_W    = $clog2(NUM_REGS)
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           i_wr_en,
  input  logic [IDX_W-1:0]               i_wr_idx,
  input  logic [AXI_DATA_W-1:0]          i_wr_data,
  input  logic [AXI_STRB_W-1:0]          i_wr_strb,
  input  logic [IDX_W-1:0]               i_rd_idx,
  output logic [AXI_DATA_W-1:0]          o_rd_data,
  output logic [NUM_REGS*AXI_DATA_W-1:0] o_reg_q,
  output logic [NUM_REGS-1:0]            o_reg_wr
);

`ifdef AXI_LITE_SLAVE_ID_REG_EN
  localparam int RW_REGS = NUM_REGS - 1;
`else
  localparam int RW_REGS = NUM_REGS;
  logic w_unused_id;
  assign w_unused_id = ^ID_VALUE;
`endif

  logic [AXI_DATA_W-1:0] r_regs [NUM_REGS];
  logic [AXI_DATA_W-1:0] w_q    [NUM_REGS];
  logic [NUM_REGS-1:0]   r_reg_wr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the array lives in flops, not RAM, so it is reset like any other state.
      for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= '0;
      r_reg_wr <= '0;
    end else begin
      // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
      r_reg_wr <= '0;
      for (int i = 0; i < RW_REGS; i++) begin
        if (i_wr_en && i_wr_idx == IDX_W'(i)) begin
          r_reg_wr[i] <= 1'b1;
          for (int b = 0; b < AXI_STRB_W; b++) begin
            if (i_wr_strb[b]) r_regs[i][8*b +: 8] <= i_wr_data[8*b +: 8];
          end
        end
      end
    end
  end

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_q
    if (g < RW_REGS) begin : g_rw
      assign w_q[g] = r_regs[g];
    end else begin : g_id
      assign w_q[g] = ID_VALUE;
    end
    assign o_reg_q[AXI_DATA_W*g +: AXI_DATA_W] = w_q[g];
  end

  always_comb begin
    // NOTE: default first so every path assigns the output and no latch is inferred.
    o_rd_data = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (i_rd_idx == IDX_W'(i)) o_rd_data = w_q[i];
    end
  end

  assign o_reg_wr = r_reg_wr;

endmodule

// File: rtl/axi_lite_slave_regs.sv
// AXI4-Lite slave register bank: independent write/read channel FSMs over axi_lite_regfile.
// Optional read-only ID register at index NUM_REGS-1 under AXI_LITE_SLAVE_ID_REG_EN.
module axi_lite_slave_regs
  import axi_lite_pkg::*;
#(
  parameter int                    ADDR_W   = 32,
  parameter int                    NUM_REGS = 16,
  parameter logic [AXI_DATA_W-1:0] ID_VALUE = 32'hA11E_0001
) (
  input  logic                           ACLK,
  input  logic                           ARESETn,
  input  logic [ADDR_W-1:0]              S_AXI_AWADDR,
  input  logic                           S_AXI_AWVALID,
  output logic                           S_AXI_AWREADY,
  input  logic [2:0]                     S_AXI_AWPROT,
  input  logic [AXI_DATA_W-1:0]          S_AXI_WDATA,
  input  logic [AXI_STRB_W-1:0]          S_AXI_WSTRB,
  input  logic                           S_AXI_WVALID,
  output logic                           S_AXI_WREADY,
  output logic [1:0]                     S_AXI_BRESP,
  output logic                           S_AXI_BVALID,
  input  logic                           S_AXI_BREADY,
  input  logic [ADDR_W-1:0]              S_AXI_ARADDR,
  input  logic                           S_AXI_ARVALID,
  output logic                           S_AXI_ARREADY,
  input  logic [2:0]                     S_AXI_ARPROT,
  output logic [AXI_DATA_W-1:0]          S_AXI_RDATA,
  output logic [1:0]                     S_AXI_RRESP,
  output logic                           S_AXI_RVALID,
  input  logic                           S_AXI_RREADY,
  output logic [NUM_REGS*AXI_DATA_W-1:0] REG_Q,
  output logic [NUM_REGS-1:0]            REG_WR
);

  localparam int                IDX_W = $clog2(NUM_REGS);
  localparam logic [ADDR_W-1:0] LIMIT = ADDR_W'(NUM_REGS);

  wr_state_t             r_state, w_state_next;
  logic                  r_aw_got, r_w_got, w_aw_got_next, w_w_got_next;
  logic                  r_awready, r_wready, w_awready_next, w_wready_next;
  logic                  r_bvalid, w_bvalid_next;
  axi_resp_t             r_bresp, w_bresp_next;
  logic [ADDR_W-3:0]     r_aw_idx;
  logic [AXI_DATA_W-1:0] r_wdata;
  logic [AXI_STRB_W-1:0] r_wstrb;
  logic                  w_aw_hs, w_w_hs, w_wr_in_range, w_wr_ok, w_wr_en;

  logic                  r_arready, r_rvalid, w_ar_hs, w_rd_in_range;
  logic [AXI_DATA_W-1:0] r_rdata, w_rd_data;
  axi_resp_t             r_rresp;

  assign w_aw_hs       = r_awready && S_AXI_AWVALID;
  assign w_w_hs        = r_wready && S_AXI_WVALID;
  assign w_wr_in_range = {2'b00, r_aw_idx} < LIMIT;
`ifdef AXI_LITE_SLAVE_ID_REG_EN
  assign w_wr_ok = w_wr_in_range && ({2'b00, r_aw_idx} != ADDR_W'(NUM_REGS - 1));
`else
  assign w_wr_ok = w_wr_in_range;
`endif

  always_comb begin
    w_state_next  = r_state;
    w_aw_got_next = r_aw_got;
    w_w_got_next  = r_w_got;
    w_bvalid_next = r_bvalid;
    w_bresp_next  = r_bresp;
    w_wr_en       = 1'b0;
    case (r_state)
      W_IDLE: begin
        w_aw_got_next = r_aw_got || w_aw_hs;
        w_w_got_next  = r_w_got || w_w_hs;
        if (w_aw_got_next && w_w_got_next) w_state_next = W_COMMIT;
      end
      W_COMMIT: begin
        w_wr_en      = w_wr_ok;
        w_bresp_next = w_wr_ok ? RESP_OKAY : RESP_SLVERR;
        w_state_next = W_RESP;
      end
      W_RESP: begin
        if (r_bvalid && S_AXI_BREADY) begin
          w_bvalid_next = 1'b0;
          w_aw_got_next = 1'b0;
          w_w_got_next  = 1'b0;
          w_state_next  = W_IDLE;
        end else begin
          w_bvalid_next = 1'b1;
        end
      end
      default: w_state_next = W_IDLE;
    endcase
    // Ready is registered so it sits low while reset is asserted.
    w_awready_next = (w_state_next == W_IDLE) && !w_aw_got_next;
    w_wready_next  = (w_state_next == W_IDLE) && !w_w_got_next;
  end

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      r_state   <= W_IDLE;
      r_aw_got  <= 1'b0;
      r_w_got   <= 1'b0;
      r_awready <= 1'b0;
      r_wready  <= 1'b0;
      r_bvalid  <= 1'b0;
      r_bresp   <= RESP_OKAY;
      r_aw_idx  <= '0;
      r_wdata   <= '0;
      r_wstrb   <= '0;
    end else begin
      r_state   <= w_state_next;
      r_aw_got  <= w_aw_got_next;
      r_w_got   <= w_w_got_next;
      r_awready <= w_awready_next;
      r_wready  <= w_wready_next;
      r_bvalid  <= w_bvalid_next;
      r_bresp   <= w_bresp_next;
      if (w_aw_hs) r_aw_idx <= S_AXI_AWADDR[ADDR_W-1:2];
      if (w_w_hs) begin
        r_wdata <= S_AXI_WDATA;
        r_wstrb <= S_AXI_WSTRB;
      end
    end
  end

  assign w_ar_hs       = r_arready && S_AXI_ARVALID;
  assign w_rd_in_range = {2'b00, S_AXI_ARADDR[ADDR_W-1:2]} < LIMIT;

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      r_arready <= 1'b0;
      r_rvalid  <= 1'b0;
      r_rdata   <= '0;
      r_rresp   <= RESP_OKAY;
    end else begin
      if (w_ar_hs) begin
        r_rvalid <= 1'b1;
        r_rdata  <= w_rd_in_range ? w_rd_data : '0;
        r_rresp  <= w_rd_in_range ? RESP_OKAY : RESP_SLVERR;
      end else if (r_rvalid && S_AXI_RREADY) begin
        r_rvalid <= 1'b0;
      end
      r_arready <= !(w_ar_hs || (r_rvalid && !S_AXI_RREADY));
    end
  end

  axi_lite_regfile #(
    .NUM_REGS (NUM_REGS),
    .ID_VALUE (ID_VALUE),
    .IDX_W    (IDX_W)
  ) u_regfile (
    .clk       (ACLK),
    .rst_n     (ARESETn),
    .i_wr_en   (w_wr_en),
    .i_wr_idx  (r_aw_idx[IDX_W-1:0]),
    .i_wr_data (r_wdata),
    .i_wr_strb (r_wstrb),
    .i_rd_idx  (S_AXI_ARADDR[IDX_W+1:2]),
    .o_rd_data (w_rd_data),
    .o_reg_q   (REG_Q),
    .o_reg_wr  (REG_WR)
  );

  logic w_unused;
  assign w_unused = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

  assign S_AXI_AWREADY = r_awready;
  assign S_AXI_WREADY  = r_wready;
  assign S_AXI_BVALID  = r_bvalid;
  assign S_AXI_BRESP   = r_bresp;
  assign S_AXI_ARREADY = r_arready;
  assign S_AXI_RVALID  = r_rvalid;
  assign S_AXI_RDATA   = r_rdata;
  assign S_AXI_RRESP   = r_rresp;

endmodule

// File: tb/tb_axi_lite_slave_regs.sv
// Directed self-checking bench for axi_lite_slave_regs (default NUM_REGS=16, ADDR_W=32).
module tb_axi_lite_slave_regs;

  localparam int ADDR_W   = 32;
  localparam int NUM_REGS = 16;

  logic                     ACLK, ARESETn;
  logic [ADDR_W-1:0]        S_AXI_AWADDR, S_AXI_ARADDR;
  logic                     S_AXI_AWVALID, S_AXI_AWREADY;
  logic [2:0]               S_AXI_AWPROT, S_AXI_ARPROT;
  logic [31:0]              S_AXI_WDATA, S_AXI_RDATA;
  logic [3:0]               S_AXI_WSTRB;
  logic                     S_AXI_WVALID, S_AXI_WREADY;
  logic [1:0]               S_AXI_BRESP, S_AXI_RRESP;
  logic                     S_AXI_BVALID, S_AXI_BREADY;
  logic                     S_AXI_ARVALID, S_AXI_ARREADY;
  logic                     S_AXI_RVALID, S_AXI_RREADY;
  logic [NUM_REGS*32-1:0]   REG_Q;
  logic [NUM_REGS-1:0]      REG_WR;

  int n_checks = 0;
  int n_errors = 0;

  logic [NUM_REGS-1:0] wr_seen;
  logic                wr_seen_clr;

  axi_lite_slave_regs #(
    .ADDR_W   (ADDR_W),
    .NUM_REGS (NUM_REGS),
    .ID_VALUE (32'hA11E_0001)
  ) dut (
    .ACLK          (ACLK),
    .ARESETn       (ARESETn),
    .S_AXI_AWADDR  (S_AXI_AWADDR),
    .S_AXI_AWVALID (S_AXI_AWVALID),
    .S_AXI_AWREADY (S_AXI_AWREADY),
    .S_AXI_AWPROT  (S_AXI_AWPROT),
    .S_AXI_WDATA   (S_AXI_WDATA),
    .S_AXI_WSTRB   (S_AXI_WSTRB),
    .S_AXI_WVALID  (S_AXI_WVALID),
    .S_AXI_WREADY  (S_AXI_WREADY),
    .S_AXI_BRESP   (S_AXI_BRESP),
    .S_AXI_BVALID  (S_AXI_BVALID),
    .S_AXI_BREADY  (S_AXI_BREADY),
    .S_AXI_ARADDR  (S_AXI_ARADDR),
    .S_AXI_ARVALID (S_AXI_ARVALID),
    .S_AXI_ARREADY (S_AXI_ARREADY),
    .S_AXI_ARPROT  (S_AXI_ARPROT),
    .S_AXI_RDATA   (S_AXI_RDATA),
    .S_AXI_RRESP   (S_AXI_RRESP),
    .S_AXI_RVALID  (S_AXI_RVALID),
    .S_AXI_RREADY  (S_AXI_RREADY),
    .REG_Q         (REG_Q),
    .REG_WR        (REG_WR)
  );

  initial ACLK = 1'b0;
  always #5 ACLK = ~ACLK;

  always @(posedge ACLK) begin
    if (wr_seen_clr) wr_seen <= '0;
    else             wr_seen <= wr_seen | REG_WR;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge ACLK);
    #1;
  endtask

  task automatic clr_seen();
    wr_seen_clr = 1'b1;
    tick();
    wr_seen_clr = 1'b0;
  endtask

  // W is presented w_lead cycles before AW (0 = same cycle).
  task automatic do_write(input logic [31:0] addr, input logic [31:0] data,
                          input logic [3:0] strb, input int w_lead, output logic [1:0] resp);
    int   aw_delay;
    logic aw_acc, w_acc;
    S_AXI_AWADDR  = addr;
    S_AXI_WDATA   = data;
    S_AXI_WSTRB   = strb;
    S_AXI_WVALID  = 1'b1;
    aw_delay      = w_lead;
    S_AXI_AWVALID = (w_lead == 0);
    for (int c = 0; c < 64 && (S_AXI_AWVALID || S_AXI_WVALID || aw_delay > 0); c++) begin
      aw_acc = S_AXI_AWVALID && S_AXI_AWREADY;
      w_acc  = S_AXI_WVALID && S_AXI_WREADY;
      tick();
      if (aw_acc) S_AXI_AWVALID = 1'b0;
      if (w_acc)  S_AXI_WVALID  = 1'b0;
      if (aw_delay > 0) begin
        aw_delay--;
        if (aw_delay == 0) S_AXI_AWVALID = 1'b1;
      end
    end
    check("wr_accept", {31'b0, S_AXI_AWVALID || S_AXI_WVALID}, 32'd0);
    S_AXI_AWVALID = 1'b0;
    S_AXI_WVALID  = 1'b0;
    for (int c = 0; c < 16 && !S_AXI_BVALID; c++) tick();
    check("wr_bvalid", {31'b0, S_AXI_BVALID}, 32'd1);
    resp = S_AXI_BRESP;
    S_AXI_BREADY = 1'b1;
    tick();
    S_AXI_BREADY = 1'b0;
  endtask

  task automatic do_read(input logic [31:0] addr, output logic [31:0] data, output logic [1:0] resp);
    S_AXI_ARADDR  = addr;
    S_AXI_ARVALID = 1'b1;
    for (int c = 0; c < 16 && !S_AXI_ARREADY; c++) tick();
    tick();
    S_AXI_ARVALID = 1'b0;
    check("rd_latency", {31'b0, S_AXI_RVALID}, 32'd1);
    data = S_AXI_RDATA;
    resp = S_AXI_RRESP;
    S_AXI_RREADY = 1'b1;
    tick();
    S_AXI_RREADY = 1'b0;
  endtask

  logic [31:0] d;
  logic [1:0]  r;
  logic        ok;

  initial begin
    ARESETn = 1'b0;
    S_AXI_AWADDR = '0; S_AXI_AWVALID = 1'b0; S_AXI_AWPROT = '0;
    S_AXI_WDATA = '0; S_AXI_WSTRB = '0; S_AXI_WVALID = 1'b0; S_AXI_BREADY = 1'b0;
    S_AXI_ARADDR = '0; S_AXI_ARVALID = 1'b0; S_AXI_ARPROT = '0; S_AXI_RREADY = 1'b0;
    wr_seen_clr = 1'b1;
    repeat (3) tick();
    check("rst_awready", {31'b0, S_AXI_AWREADY}, 32'd0);
    check("rst_wready",  {31'b0, S_AXI_WREADY},  32'd0);
    check("rst_arready", {31'b0, S_AXI_ARREADY}, 32'd0);
    check("rst_bvalid",  {31'b0, S_AXI_BVALID},  32'd0);
    check("rst_rvalid",  {31'b0, S_AXI_RVALID},  32'd0);
    check("rst_rdata",   S_AXI_RDATA, 32'd0);
    check("rst_reg_wr",  {16'b0, REG_WR}, 32'd0);
    check("rst_regq",    {31'b0, REG_Q == '0}, 32'd1);
    ARESETn = 1'b1;
    wr_seen_clr = 1'b0;
    tick();

    // Same-cycle AW+W to 0x08, exact latency
    S_AXI_AWADDR = 32'h08; S_AXI_AWVALID = 1'b1;
    S_AXI_WDATA = 32'hDEADBEEF; S_AXI_WSTRB = 4'hF; S_AXI_WVALID = 1'b1;
    check("t1_awready", {31'b0, S_AXI_AWREADY}, 32'd1);
    check("t1_wready",  {31'b0, S_AXI_WREADY},  32'd1);
    tick();
    S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0;
    check("t1_awready_busy", {31'b0, S_AXI_AWREADY}, 32'd0);
    check("t1_bvalid_n0",    {31'b0, S_AXI_BVALID},  32'd0);
    tick();
    check("t1_reg_wr",    {16'b0, REG_WR}, 32'h0000_0004);
    check("t1_regq",      REG_Q[2*32 +: 32], 32'hDEADBEEF);
    check("t1_bvalid_n1", {31'b0, S_AXI_BVALID}, 32'd0);
    tick();
    check("t1_bvalid_n2", {31'b0, S_AXI_BVALID}, 32'd1);
    check("t1_bresp",     {30'b0, S_AXI_BRESP}, 32'd0);
    check("t1_reg_wr_end", {16'b0, REG_WR}, 32'd0);
    S_AXI_BREADY = 1'b1;
    tick();
    S_AXI_BREADY = 1'b0;
    check("t1_bvalid_done", {31'b0, S_AXI_BVALID}, 32'd0);
    check("t1_awready_back", {31'b0, S_AXI_AWREADY}, 32'd1);
    do_read(32'h08, d, r);
    check("t1_rdata", d, 32'hDEADBEEF);
    check("t1_rresp", {30'b0, r}, 32'd0);

    // W three cycles ahead of AW, then a single-byte strobe
    do_write(32'h04, 32'h11223344, 4'hF, 3, r);
    check("t2_bresp_a", {30'b0, r}, 32'd0);
    do_write(32'h04, 32'hFFFFFFFF, 4'h2, 0, r);
    check("t2_bresp_b", {30'b0, r}, 32'd0);
    do_read(32'h04, d, r);
    check("t2_rdata", d, 32'h1122FF44);
    check("t2_regq",  REG_Q[1*32 +: 32], 32'h1122FF44);

    // Out-of-range accesses; 0x108 would alias onto index 2 if decode were truncated
    clr_seen();
    do_write(32'h100, 32'h55555555, 4'hF, 0, r);
    check("t3_bresp", {30'b0, r}, 32'h2);
    do_write(32'h108, 32'h66666666, 4'hF, 1, r);
    check("t3_bresp_alias", {30'b0, r}, 32'h2);
    check("t3_no_reg_wr", {16'b0, wr_seen}, 32'd0);
    check("t3_reg2_kept", REG_Q[2*32 +: 32], 32'hDEADBEEF);
    do_read(32'h100, d, r);
    check("t3_rdata", d, 32'd0);
    check("t3_rresp", {30'b0, r}, 32'h2);
    do_read(32'h108, d, r);
    check("t3_rdata_alias", d, 32'd0);

    // Zero strobe still completes and pulses
    clr_seen();
    do_write(32'h08, 32'h00000000, 4'h0, 0, r);
    check("t4_bresp", {30'b0, r}, 32'd0);
    check("t4_reg_wr", {16'b0, wr_seen}, 32'h0000_0004);
    check("t4_regq", REG_Q[2*32 +: 32], 32'hDEADBEEF);

    // BREADY held low
    S_AXI_AWADDR = 32'h0C; S_AXI_AWVALID = 1'b1;
    S_AXI_WDATA = 32'hA5A5A5A5; S_AXI_WSTRB = 4'hF; S_AXI_WVALID = 1'b1;
    tick();
    S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0;
    tick(); tick();
    ok = 1'b1;
    repeat (10) begin
      ok &= S_AXI_BVALID && (S_AXI_BRESP == 2'b00) && !S_AXI_AWREADY && !S_AXI_WREADY;
      tick();
    end
    check("t5_b_stall", {31'b0, ok}, 32'd1);
    S_AXI_BREADY = 1'b1;
    tick();
    S_AXI_BREADY = 1'b0;
    check("t5_bvalid_done", {31'b0, S_AXI_BVALID}, 32'd0);

    // RREADY held low
    S_AXI_ARADDR = 32'h0C; S_AXI_ARVALID = 1'b1;
    tick();
    S_AXI_ARVALID = 1'b0;
    ok = 1'b1;
    repeat (10) begin
      ok &= S_AXI_RVALID && (S_AXI_RDATA == 32'hA5A5A5A5) && (S_AXI_RRESP == 2'b00) && !S_AXI_ARREADY;
      tick();
    end
    check("t5_r_stall", {31'b0, ok}, 32'd1);
    S_AXI_RREADY = 1'b1;
    tick();
    S_AXI_RREADY = 1'b0;
    check("t5_rvalid_done", {31'b0, S_AXI_RVALID}, 32'd0);
    check("t5_arready_back", {31'b0, S_AXI_ARREADY}, 32'd1);

    // Read accepted on the commit edge sees the old value
    S_AXI_AWADDR = 32'h0C; S_AXI_AWVALID = 1'b1;
    S_AXI_WDATA = 32'h5A5A5A5A; S_AXI_WSTRB = 4'hF; S_AXI_WVALID = 1'b1;
    tick();
    S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0;
    S_AXI_ARADDR = 32'h0C; S_AXI_ARVALID = 1'b1;
    tick();
    S_AXI_ARVALID = 1'b0;
    check("t6_rdata_old", S_AXI_RDATA, 32'hA5A5A5A5);
    S_AXI_RREADY = 1'b1; S_AXI_BREADY = 1'b1;
    tick();
    check("t6_bvalid", {31'b0, S_AXI_BVALID}, 32'd1);
    tick();
    S_AXI_RREADY = 1'b0; S_AXI_BREADY = 1'b0;
    do_read(32'h0C, d, r);
    check("t6_rdata_new", d, 32'h5A5A5A5A);

    // Reset while BVALID is pending
    S_AXI_AWADDR = 32'h10; S_AXI_AWVALID = 1'b1;
    S_AXI_WDATA = 32'h12345678; S_AXI_WSTRB = 4'hF; S_AXI_WVALID = 1'b1;
    tick();
    S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0;
    tick(); tick();
    check("t7_bvalid_pre", {31'b0, S_AXI_BVALID}, 32'd1);
    ARESETn = 1'b0;
    #1;
    check("t7_bvalid_rst", {31'b0, S_AXI_BVALID}, 32'd0);
    check("t7_regq_rst",   {31'b0, REG_Q == '0}, 32'd1);
    tick();
    ARESETn = 1'b1;
    tick();
    do_write(32'h10, 32'hCAFEF00D, 4'hF, 0, r);
    check("t7_bresp", {30'b0, r}, 32'd0);
    do_read(32'h10, d, r);
    check("t7_rdata", d, 32'hCAFEF00D);
    do_read(32'h08, d, r);
    check("t7_reg2_cleared", d, 32'd0);

    // Last register: ID or plain read/write
`ifdef AXI_LITE_SLAVE_ID_REG_EN
    do_read(32'h3C, d, r);
    check("t8_id_rdata", d, 32'hA11E0001);
    check("t8_id_rresp", {30'b0, r}, 32'd0);
    clr_seen();
    do_write(32'h3C, 32'h12345678, 4'hF, 0, r);
    check("t8_id_bresp", {30'b0, r}, 32'h2);
    check("t8_id_no_wr", {16'b0, wr_seen}, 32'd0);
    do_read(32'h3C, d, r);
    check("t8_id_kept", d, 32'hA11E0001);
    check("t8_id_regq", REG_Q[15*32 +: 32], 32'hA11E0001);
`else
    do_write(32'h3C, 32'h0BADF00D, 4'hF, 0, r);
    check("t8_last_bresp", {30'b0, r}, 32'd0);
    do_read(32'h3C, d, r);
    check("t8_last_rdata", d, 32'h0BADF00D);
    check("t8_last_regq", REG_Q[15*32 +: 32], 32'h0BADF00D);
`endif

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/axi_lite_slave_regs.md
Name: axi_lite_slave_regs

Overview:
AXI4-Lite slave register bank that sits directly downstream of axi_lite_master. It replaces the VIP slave in system builds and is a drop-in target for the same bench.
- Accepts single-beat writes and reads into NUM_REGS 32-bit registers.
- Supports byte strobes and returns SLVERR for out-of-range addresses.
- Exports register contents and a per-register write pulse to fabric logic.

Parameters:
ADDR_W, 32, AXI address width.
NUM_REGS, 16, number of 32-bit registers, 2..256.
ID_VALUE, 32'hA11E_0001, constant returned by the ID register (optional feature only).

Ports:
ACLK  in  1  clock, all logic on rising edge
ARESETn  in  1  asynchronous active-low reset
S_AXI_AWADDR  in  ADDR_W  write address
S_AXI_AWVALID  in  1  write address valid
S_AXI_AWREADY  out  1  write address ready
S_AXI_AWPROT  in  3  ignored
S_AXI_WDATA  in  32  write data
S_AXI_WSTRB  in  4  byte strobes
S_AXI_WVALID  in  1  write data valid
S_AXI_WREADY  out  1  write data ready
S_AXI_BRESP  out  2  write response
S_AXI_BVALID  out  1  write response valid
S_AXI_BREADY  in  1  write response ready
S_AXI_ARADDR  in  ADDR_W  read address
S_AXI_ARVALID  in  1  read address valid
S_AXI_ARREADY  out  1  read address ready
S_AXI_ARPROT  in  3  ignored
S_AXI_RDATA  out  32  read data
S_AXI_RRESP  out  2  read response
S_AXI_RVALID  out  1  read data valid
S_AXI_RREADY  in  1  read data ready
REG_Q  out  NUM_REGS*32  flattened register contents, reg i at [32*i+:32]
REG_WR  out  NUM_REGS  one-cycle pulse per register written

Behaviour:
- Reset (asynchronous, ARESETn=0): all registers 0. AWREADY, WREADY, BVALID, ARREADY, RVALID, REG_WR = 0. BRESP, RRESP, RDATA = 0. Internal captured flags cleared. Reset mid-transaction drops the transaction; no response is issued.
- Decode: index = ADDR[ADDR_W-1:2]; ADDR[1:0] ignored. index >= NUM_REGS is out of range.
- Write FSM states:
  - W_IDLE: AWREADY=~aw_got, WREADY=~w_got. AW and W are captured independently, in either order or in the same cycle.
  - When both are captured (including capture on this edge), go to W_COMMIT.
  - W_COMMIT (1 cycle): if in range, update bytes where WSTRB[b]=1, pulse REG_WR[index], BRESP=OKAY. If out of range, no update, BRESP=SLVERR. BVALID=1 next cycle; go to W_RESP.
  - W_RESP: BVALID held, BRESP stable until BREADY. On handshake, clear flags and return to W_IDLE.
  - AWREADY and WREADY stay 0 in W_COMMIT and W_RESP. Max one outstanding write.
  - Latency: both channels accepted at edge N gives BVALID=1 at edge N+2.
- Read path:
  - ARREADY = ~RVALID (registered, 0 in reset).
  - On AR handshake at edge N: RVALID=1 and RDATA/RRESP registered at N+1.
  - Out-of-range read: RDATA=0, RRESP=SLVERR.
  - RVALID, RDATA, RRESP held stable until RREADY. Handshake clears RVALID; ARREADY reasserts the following cycle. Max one outstanding read.
- Write and read paths are fully independent.
- A read accepted on the same edge as a W_COMMIT to the same index returns the pre-write value.
- WSTRB=0 still completes with OKAY and pulses REG_WR, with no data change.
- REG_Q is a direct register output, updated the cycle after W_COMMIT.

Optional Feature:
Macro AXI_LITE_SLAVE_ID_REG_EN.
- Defined: register NUM_REGS-1 is read-only and reads ID_VALUE with OKAY. Writes to it leave it unchanged, return SLVERR, and give no REG_WR pulse. REG_Q slice for it = ID_VALUE.
- Undefined: all NUM_REGS registers are read/write and ID_VALUE is unused.

Decomposition:
- Package axi_lite_pkg holds:
  - typedef axi_resp_t (2 bits), with constants RESP_OKAY=2'b00 and RESP_SLVERR=2'b10.
  - write FSM state enum wr_state_t {W_IDLE, W_COMMIT, W_RESP}.
  - constant AXI_DATA_W=32.
- One sub-module, axi_lite_regfile: byte-strobed register array with write port (en, index, data, strb), combinational read port, and REG_Q/REG_WR outputs. The top holds both channel FSMs.

Test Plan:
- Reset release, write 0x08 data 0xDEADBEEF WSTRB=0xF with AW and W in the same cycle -> BVALID 2 cycles later, BRESP=00, REG_WR[2] pulse, read 0x08 returns 0xDEADBEEF RRESP=00.
- W sent 3 cycles before AW to 0x04 data 0x11223344, then WSTRB=0x2 data 0xFFFFFFFF to 0x04 -> read 0x04 returns 0x1122FF44.
- Write and read 0x100 (index 64 >= 16) -> BRESP=10, RRESP=10, RDATA=0, no REG_WR bit set.
- BREADY low 10 cycles -> BVALID/BRESP stable, AWREADY=WREADY=0 throughout. RREADY low 10 cycles -> RDATA stable, ARREADY=0.
- Assert ARESETn=0 during W_RESP -> BVALID=0 immediately, all registers 0. After release, a new write completes normally.
- With AXI_LITE_SLAVE_ID_REG_EN: read 0x3C -> 0xA11E0001 OKAY. Write 0x3C -> SLVERR and value unchanged. Without the macro: write/read 0x3C round-trips.
